pc_branch_ctrl: RTL and testbench
=================================

// Module: pc_branch_ctrl
// PURPOSE
//   Fetch/next-PC stage of the multi-cycle RV32I datapath. Holds the PC and fetches through a req/ack
//   instruction-memory handshake. It presents the instruction for one execute cycle, then consumes the
//   ALU less/zero flags with the decoded Branch code to select and commit the next PC.
//   Also maintains a retired-instruction counter and traps on misaligned jump/branch targets.
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC value loaded on reset; must be 4-byte aligned
// PORTS
//   clk          in   1   single clock; all state changes on posedge
//   rst          in   1   reset, synchronous, active-high
//   imem_req     out  1   fetch request, held high until imem_ack
//   imem_addr    out  32  fetch address (= pc)
//   imem_ack     in   1   instruction-memory ack; imem_rdata valid in the same cycle
//   imem_rdata   in   32  fetched instruction word
//   instr        out  32  latched instruction fed to decode/ALU
//   instr_valid  out  1   high in EXEC: branch/less/zero/imm/rs1 must be valid this cycle
//   branch       in   3   decoded Branch code (see BEHAVIOUR)
//   less         in   1   ALU less flag
//   zero         in   1   ALU zero flag
//   imm          in   32  decoded immediate (already sign-extended)
//   rs1          in   32  register rs1 value (used for jalr)
//   stall        in   1   hold EXEC; no PC commit, no retire
//   pc           out  32  PC of the current instruction
//   pc_plus4     out  32  pc+4 (link value for jal/jalr writeback)
//   instret      out  32  retired-instruction count
//   trap_misalign out 1   sticky: a taken target had addr[1]!=0
// BEHAVIOUR
//   States: FETCH -> EXEC -> FETCH ...; HALT is terminal until rst.
//   Reset (rst high at posedge): state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, instret=0,
//     trap_misalign=0. imem_req=0 in any cycle where rst is high.
//   FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, go to EXEC. imem_ack outside
//     FETCH is ignored.
//   EXEC: instr_valid=1. If stall: remain in EXEC with all state unchanged.
//     Else: compute target, commit pc<=next, instret<=instret+1, go to FETCH.
//   Minimum latency: 2 cycles/instruction (ack in first FETCH cycle, no stall).
//   Next-PC selection (all sums modulo 2^32):
//     000 none  -> pc+4
//     001 jal   -> pc+imm
//     010 jalr  -> (rs1+imm) & ~32'h1
//     100 beq   -> zero ? pc+imm : pc+4
//     101 bne   -> !zero ? pc+imm : pc+4
//     110 blt/u -> less ? pc+imm : pc+4
//     111 bge/u -> !less ? pc+imm : pc+4
//     011 reserved -> pc+4
//   Misalign: a taken target with bit[1]=1 (jalr: bit[1] after masking) sets trap_misalign.
//     The pc is not updated, instret does not increment, and the state goes to HALT.
//     Not-taken branches never trap.
//   HALT: imem_req=0, instr_valid=0, all registers frozen; only rst exits.
//   Wrap-around: pc=32'hFFFF_FFFC with branch=000 -> next pc=0, no trap. instret wraps FFFF_FFFF -> 0.
//   rst mid-FETCH or mid-EXEC: outstanding request abandoned; imem shares rst, so no late ack is accepted.
//   pc_plus4 is combinational from pc; instr is stable from the EXEC entry until the next ack.
// TESTING
//   1 rst 2 cycles, release; ack immediately each fetch, branch=000 x3 -> pc 0,4,8,C; instret=3.
//   2 pc=0x10, branch=100, zero=1, imm=-8 -> pc=0x08; repeat with zero=0 -> pc=0x14.
//   3 branch=010, rs1=0x101, imm=0x0F -> pc=0x110 (bit0 cleared); rs1=0x102, imm=0 -> trap, pc held, HALT.
//   4 stall high 3 EXEC cycles, then low -> pc/instret change only after release; instr held.
//   5 imem_ack delayed 4 cycles -> imem_req high throughout, addr stable; pc=FFFF_FFFC, branch=000 -> pc=0.
//   6 rst asserted while in EXEC and while in HALT -> next cycle FETCH, pc=RESET_PC, trap_misalign=0.

Source files
------------

// File: rtl/pc_branch_ctrl_if.sv
// ============================================================================
// Module   : pc_branch_ctrl_if
// Purpose  : Fetch/next-PC stage signal bundle (imem handshake, decode inputs, PC state)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_branch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [2:0]  branch;
  logic        less;
  logic        zero;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instret;
  logic        trap_misalign;

  // master is the fetch stage itself; slave is memory plus decode/ALU side
  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, instret, trap_misalign,
    input  imem_ack, imem_rdata, branch, less, zero, imm, rs1, stall
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, instret, trap_misalign,
    output imem_ack, imem_rdata, branch, less, zero, imm, rs1, stall
  );
endinterface

`default_nettype wire

// File: rtl/pc_branch_ctrl.sv
// ============================================================================
// Module   : pc_branch_ctrl
// Purpose  : RV32I multi-cycle fetch / next-PC stage with retire counter and misalign trap
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_branch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pc_branch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instret;
  logic        r_trap;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_imm;
  logic [31:0] w_jalr_tgt;
  logic [31:0] w_target;
  logic [31:0] w_next_pc;
  logic        w_taken;
  logic        w_misalign;
  logic        w_fetch_done;
  logic        w_commit;
  logic        w_trap_set;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_pc_imm   = r_pc + bus.imm;
  assign w_jalr_tgt = (bus.rs1 + bus.imm) & ~32'h1;

  always_comb begin
    w_taken  = 1'b0;
    w_target = w_pc_imm;
    unique case (bus.branch)
      3'b001:  w_taken = 1'b1;
      3'b010: begin
        w_taken  = 1'b1;
        w_target = w_jalr_tgt;
      end
      3'b100:  w_taken = bus.zero;
      3'b101:  w_taken = ~bus.zero;
      3'b110:  w_taken = bus.less;
      3'b111:  w_taken = ~bus.less;
      default: w_taken = 1'b0;
    endcase
  end

  // Only a taken target can trap; the fall-through pc+4 is always aligned.
  assign w_next_pc  = w_taken ? w_target : w_pc_plus4;
  assign w_misalign = w_taken & w_target[1];

  always_comb begin
    w_next_state = r_state;
    w_fetch_done = 1'b0;
    w_commit     = 1'b0;
    w_trap_set   = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        if (bus.imem_ack) begin
          w_fetch_done = 1'b1;
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!bus.stall) begin
          if (w_misalign) begin
            w_trap_set   = 1'b1;
            w_next_state = ST_HALT;
          end else begin
            w_commit     = 1'b1;
            w_next_state = ST_FETCH;
          end
        end
      end
      default: w_next_state = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC;
      r_instr   <= 32'h0;
      r_instret <= 32'h0;
      r_trap    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_fetch_done) r_instr <= bus.imem_rdata;
      if (w_commit) begin
        r_pc      <= w_next_pc;
        r_instret <= r_instret + 32'd1;
      end
      if (w_trap_set) r_trap <= 1'b1;
    end
  end

  // Request is masked by rst so a reset cycle never issues a fetch.
  assign bus.imem_req      = (r_state == ST_FETCH) & ~rst;
  assign bus.imem_addr     = r_pc;
  assign bus.instr         = r_instr;
  assign bus.instr_valid   = (r_state == ST_EXEC);
  assign bus.pc            = r_pc;
  assign bus.pc_plus4      = w_pc_plus4;
  assign bus.instret       = r_instret;
  assign bus.trap_misalign = r_trap;

endmodule

`default_nettype wire

// File: tb/tb_pc_branch_ctrl.sv
// ============================================================================
// Module   : tb_pc_branch_ctrl
// Purpose  : Directed self-checking bench for pc_branch_ctrl
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_branch_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [31:0] m_pc;
  logic [31:0] m_instret;

  pc_branch_ctrl_if bus();

  pc_branch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One full instruction: fetch with dly wait cycles, stl stall cycles in EXEC, then commit or trap.
  task automatic run_instr(input logic [2:0] br, input logic l, input logic z,
                           input logic [31:0] im, input logic [31:0] r1,
                           input int dly, input int stl,
                           input logic [31:0] exp_pc, input logic exp_trap);
    logic [31:0] word;
    word = m_pc ^ 32'hA5A5_0013;
    chk("fetch_req", {31'h0, bus.imem_req}, 32'h1);
    chk("fetch_addr", bus.imem_addr, m_pc);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("wait_req", {31'h0, bus.imem_req}, 32'h1);
      chk("wait_addr", bus.imem_addr, m_pc);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    @(negedge clk);
    bus.branch = br; bus.less = l; bus.zero = z; bus.imm = im; bus.rs1 = r1;
    chk("exec_valid", {31'h0, bus.instr_valid}, 32'h1);
    chk("exec_instr", bus.instr, word);
    chk("exec_pc4", bus.pc_plus4, m_pc + 32'd4);
    // keep ack high with different data during stalls: it must be ignored
    bus.imem_rdata = ~word;
    if (stl == 0) bus.imem_ack = 1'b0;
    bus.stall = (stl != 0);
    for (int i = 0; i < stl; i++) begin
      @(negedge clk);
      chk("stall_pc", bus.pc, m_pc);
      chk("stall_ret", bus.instret, m_instret);
      chk("stall_instr", bus.instr, word);
      chk("stall_valid", {31'h0, bus.instr_valid}, 32'h1);
    end
    bus.imem_ack = 1'b0;
    bus.stall    = 1'b0;
    @(negedge clk);
    if (exp_trap) begin
      chk("trap_flag", {31'h0, bus.trap_misalign}, 32'h1);
      chk("trap_pc", bus.pc, m_pc);
      chk("trap_ret", bus.instret, m_instret);
      chk("trap_req", {31'h0, bus.imem_req}, 32'h0);
      chk("trap_valid", {31'h0, bus.instr_valid}, 32'h0);
    end else begin
      m_pc      = exp_pc;
      m_instret = m_instret + 32'd1;
      chk("next_pc", bus.pc, m_pc);
      chk("instret", bus.instret, m_instret);
      chk("no_trap", {31'h0, bus.trap_misalign}, 32'h0);
    end
    bus.branch = 3'b000;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
    end
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("rst_ret", bus.instret, 32'h0);
    chk("rst_trap", {31'h0, bus.trap_misalign}, 32'h0);
    rst = 1'b0;
    m_pc = 32'h0;
    m_instret = 32'h0;
    #1;
    chk("post_rst_req", {31'h0, bus.imem_req}, 32'h1);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
    bus.branch = 3'b000; bus.less = 1'b0; bus.zero = 1'b0;
    bus.imm = 32'h0; bus.rs1 = 32'h0; bus.stall = 1'b0;
    m_pc = 32'h0; m_instret = 32'h0;
    @(negedge clk);
    do_reset(2);

    // sequential fetches
    run_instr(3'b000, 0, 0, 32'h0, 32'h0, 0, 0, 32'h04, 0);
    run_instr(3'b000, 0, 0, 32'h0, 32'h0, 0, 0, 32'h08, 0);
    run_instr(3'b000, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0C, 0);
    chk("instret_3", bus.instret, 32'd3);
    run_instr(3'b000, 0, 0, 32'h0, 32'h0, 0, 0, 32'h10, 0);
    // conditional branches
    run_instr(3'b100, 0, 1, 32'hFFFF_FFF8, 32'h0, 0, 0, 32'h08, 0);
    run_instr(3'b000, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0C, 0);
    run_instr(3'b000, 0, 0, 32'h0, 32'h0, 0, 0, 32'h10, 0);
    run_instr(3'b100, 0, 0, 32'hFFFF_FFF8, 32'h0, 0, 0, 32'h14, 0);
    run_instr(3'b101, 0, 0, 32'h20, 32'h0, 0, 0, 32'h34, 0);
    run_instr(3'b101, 0, 1, 32'h20, 32'h0, 0, 0, 32'h38, 0);
    run_instr(3'b110, 1, 0, 32'h08, 32'h0, 0, 0, 32'h40, 0);
    run_instr(3'b110, 0, 0, 32'h08, 32'h0, 0, 0, 32'h44, 0);
    run_instr(3'b111, 0, 0, 32'hFFFF_FFFC, 32'h0, 0, 0, 32'h40, 0);
    run_instr(3'b111, 1, 0, 32'hFFFF_FFFC, 32'h0, 0, 0, 32'h44, 0);
    // jal, reserved code, jalr with bit0 masked
    run_instr(3'b001, 0, 0, 32'h100, 32'h0, 0, 0, 32'h144, 0);
    run_instr(3'b011, 1, 1, 32'h100, 32'h0, 0, 0, 32'h148, 0);
    run_instr(3'b010, 0, 0, 32'h0F, 32'h101, 0, 0, 32'h110, 0);
    // stall, then a not-taken branch toward a misaligned target
    run_instr(3'b000, 0, 0, 32'h0, 32'h0, 0, 3, 32'h114, 0);
    run_instr(3'b100, 0, 0, 32'h02, 32'h0, 0, 0, 32'h118, 0);
    // delayed ack, top-of-memory wrap
    run_instr(3'b010, 0, 0, 32'h0C, 32'hFFFF_FFF0, 4, 0, 32'hFFFF_FFFC, 0);
    run_instr(3'b000, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    // misaligned jalr traps and halts
    run_instr(3'b010, 0, 0, 32'h0, 32'h102, 0, 0, 32'h0, 1);
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halt_req", {31'h0, bus.imem_req}, 32'h0);
      chk("halt_pc", bus.pc, m_pc);
      chk("halt_trap", {31'h0, bus.trap_misalign}, 32'h1);
    end
    bus.imem_ack = 1'b0;
    do_reset(1);

    // reset while in EXEC
    run_instr(3'b000, 0, 0, 32'h0, 32'h0, 0, 0, 32'h04, 0);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("exec_before_rst", {31'h0, bus.instr_valid}, 32'h1);
    do_reset(1);

    // taken branch to a misaligned target also traps
    run_instr(3'b100, 0, 1, 32'h06, 32'h0, 0, 0, 32'h0, 1);
    do_reset(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
